// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter
// and by later readers/arbiters that share a port between requesters.
package fifo_arb_pkg;

    // Upper bound on requesters any user of rr_pick may have.
    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid, searching last_grant+1, last_grant+2, ...
    // wrapping at num_req. Bits at or above num_req are never looked at.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   last_grant,
        input int unsigned           num_req
    );
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
            // last_grant < num_req and k <= num_req, so one wrap suffices
            cand = 32'(last_grant) + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if ((k <= num_req) && !res.found && valid[cand[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Purely combinational round-robin picker: returns the first valid
// requester after last_i, wrapping modulo NUM_REQ (2..16).
module rr_pick_comb
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [RR_MAX_REQ-1:0] valid_ext;
    logic [RR_IDX_W-1:0]   last_ext;
    rr_pick_t              pick;

    // Widen to the package's fixed search width, run the search, narrow back.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid_i;
        last_ext                 = '0;
        last_ext[IDX_W-1:0]      = last_i;
        pick                     = rr_pick(valid_ext, last_ext, NUM_REQ);
        found_o                  = pick.found;
        idx_o                    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick.idx == RR_IDX_W'(i)) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the synchronous FIFO write port.
// One requester owns the port from grant until its last beat or MAX_BURST
// beats; every arbitration costs one idle bubble cycle.
// Optional build macro FIFO_WR_ARBITER_PRIO0_EN: requester 0 wins every
// arbitration it is valid for; others keep round-robin order among
// themselves, and grants to 0 do not move the round-robin pointer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; pick the next valid requester (bubble cycle)
// BURST | grant_q owns the write port; beats pass straight to the FIFO
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 8,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic [NUM_REQ-1:0] rr_valid;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    logic               gnt_valid;
    logic               gnt_last;
    logic               burst_end;

`ifdef FIFO_WR_ARBITER_PRIO0_EN
    // Requester 0 bypasses the rotation; the rest rotate among themselves.
    always_comb begin
        rr_valid    = req_valid;
        rr_valid[0] = 1'b0;
        pick_found  = req_valid[0] | rr_found;
        pick_idx    = req_valid[0] ? '0 : rr_idx;
    end
`else
    // Plain rotation across every requester.
    always_comb begin
        rr_valid   = req_valid;
        pick_found = rr_found;
        pick_idx   = rr_idx;
    end
`endif

    rr_pick_comb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid_i (rr_valid),
        .last_i  (last_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

    // Next-state logic plus the zero-latency grant mux to the FIFO port.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_d       = beat_q;
        last_d       = last_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        gnt_valid    = 1'b0;
        gnt_last     = 1'b0;
        burst_end    = 1'b0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                gnt_valid    = req_valid[i];
                gnt_last     = req_last[i];
                fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == IDX_W'(i)) begin
                        req_ready[i] = ~fifo_full;
                    end
                end
                fifo_wr_en = gnt_valid & ~fifo_full;
                if (fifo_wr_en) begin
                    beat_d    = beat_q + 1'b1;
                    burst_end = gnt_last || (beat_q == CNT_W'(MAX_BURST - 1));
                end
                if (burst_end) begin
                    state_d = IDLE;
                    beat_d  = '0;
`ifdef FIFO_WR_ARBITER_PRIO0_EN
                    if (grant_q != '0) begin
                        last_d = grant_q;
                    end
`else
                    last_d  = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // The cycle that carries reset must not write, even mid-burst.
        if (rst) begin
            req_ready  = '0;
            fifo_wr_en = 1'b0;
        end
    end

    assign busy      = (state_q == BURST) && !rst;
    assign grant_idx = grant_q;

    // State, grant, beat counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            beat_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a fixed vector table for the basic burst,
// directed multi-cycle sequences, then random traffic, all checked every
// cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_full;
    logic [1:0]      grant_idx;
    logic            busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_idx    (grant_idx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic [7:0]   d;
        logic         full;
        logic         x_wr;
        logic [7:0]   x_data;
        logic         x_busy;
        logic [1:0]   x_g;
    } vec_t;

    beat_t        srcq[N][$];
    int           glog[$];
    int           wpg[$];
    int           wlog[$];
    bit           prev_busy;

    bit           use_q;
    logic [N-1:0] tv_valid, tv_last, drop;
    logic [N*DW-1:0] tv_data;
    logic         tv_full, tv_rst;

    // Model: who owns the port, beats written in this grant, last grantee.
    bit           m_busy;
    int           m_g, m_cnt, m_last;

    int           n_cmp, n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit e_wr);
        int w;
        if (rst) begin
            m_busy = 0; m_g = 0; m_cnt = 0; m_last = N - 1;
        end else if (!m_busy) begin
            w = -1;
`ifdef FIFO_WR_ARBITER_PRIO0_EN
            if (req_valid[0]) w = 0;
`endif
            if (w < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
                end
            end
            if (w >= 0) begin
                m_busy = 1; m_g = w; m_cnt = 0;
            end
        end else if (e_wr) begin
            m_cnt++;
            if (req_last[m_g] || m_cnt == MB) begin
                m_busy = 0; m_cnt = 0;
`ifdef FIFO_WR_ARBITER_PRIO0_EN
                if (m_g != 0) m_last = m_g;
`else
                m_last = m_g;
`endif
            end
        end
    endtask

    task automatic step();
        logic [N-1:0]    v, l, e_ready;
        logic [N*DW-1:0] d;
        logic            e_wr;
        @(posedge clk);
        #1;
        if (use_q) begin
            v = '0; l = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() > 0 && !drop[i]) begin
                    v[i] = 1'b1;
                    l[i] = srcq[i][0].l;
                    d[i*DW +: DW] = srcq[i][0].d;
                end
            end
            req_valid = v; req_last = l; req_data = d;
        end else begin
            req_valid = tv_valid; req_last = tv_last; req_data = tv_data;
        end
        rst       = tv_rst;
        fifo_full = tv_full;
        @(negedge clk);
        e_wr    = m_busy && req_valid[m_g] && !fifo_full && !rst;
        e_ready = (m_busy && !fifo_full && !rst) ? N'(1 << m_g) : '0;
        check("ready", 32'(req_ready), 32'(e_ready));
        check("wr_en", 32'(fifo_wr_en), 32'(e_wr));
        if (e_wr) check("wr_data", 32'(fifo_wr_data), 32'(req_data[m_g*DW +: DW]));
        check("busy", 32'(busy), 32'(m_busy && !rst));
        check("grant_idx", 32'(grant_idx), 32'(m_g));
        if (busy && !prev_busy) begin
            glog.push_back(int'(grant_idx));
            wpg.push_back(0);
        end
        if (fifo_wr_en) begin
            wlog.push_back(int'(fifo_wr_data));
            if (wpg.size() > 0) wpg[wpg.size()-1] = wpg[wpg.size()-1] + 1;
        end
        prev_busy = busy;
        if (use_q && e_wr) void'(srcq[m_g].pop_front());
        model_update(e_wr);
    endtask

    task automatic reset_dut();
        for (int i = 0; i < N; i++) srcq[i].delete();
        drop = '0; tv_full = 0; tv_valid = '0; tv_last = '0; tv_data = '0;
        tv_rst = 1;
        step();
        tv_rst = 0;
        glog.delete(); wpg.delete(); wlog.delete();
    endtask

    task automatic push_beats(input int r, input int n, input logic [7:0] base, input bit each_last);
        for (int k = 0; k < n; k++)
            srcq[r].push_back('{d: base + 8'(k), l: (each_last || k == n - 1)});
    endtask

    vec_t tbl[6];
    int   exp_w[$];
    int   nw;

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 0;
        m_busy = 0; m_g = 0; m_cnt = 0; m_last = N - 1; prev_busy = 0;
        use_q = 0;
        reset_dut();

        // Basic 3-beat burst from requester 0, fixed expectations.
        tbl[0] = '{4'b0001, 4'b0000, 8'hA1, 0, 0, 8'h00, 0, 2'd0};
        tbl[1] = '{4'b0001, 4'b0000, 8'hA1, 0, 1, 8'hA1, 1, 2'd0};
        tbl[2] = '{4'b0001, 4'b0000, 8'hA2, 0, 1, 8'hA2, 1, 2'd0};
        tbl[3] = '{4'b0001, 4'b0001, 8'hA3, 0, 1, 8'hA3, 1, 2'd0};
        tbl[4] = '{4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 0, 2'd0};
        tbl[5] = '{4'b0000, 4'b0001, 8'h00, 0, 0, 8'h00, 0, 2'd0};
        for (int i = 0; i < 6; i++) begin
            tv_valid = tbl[i].v; tv_last = tbl[i].l;
            tv_data = {24'h0, tbl[i].d}; tv_full = tbl[i].full;
            step();
            check("tbl_wr_en", 32'(fifo_wr_en), 32'(tbl[i].x_wr));
            if (tbl[i].x_wr) check("tbl_wr_data", 32'(fifo_wr_data), 32'(tbl[i].x_data));
            check("tbl_busy", 32'(busy), 32'(tbl[i].x_busy));
            check("tbl_grant", 32'(grant_idx), 32'(tbl[i].x_g));
        end

        // All four requesters, single-beat bursts: strict rotation.
        use_q = 1;
        reset_dut();
        for (int r = 0; r < N; r++) push_beats(r, 2, 8'(r * 16), 1);
        for (int k = 0; k < 20; k++) step();
        check("rr_ngrants", glog.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < glog.size()) check("rr_order", glog[k], k % N);

        // Long burst from 2 is cut at MAX_BURST; 3 goes next, then 2 resumes.
        reset_dut();
        push_beats(2, 12, 8'h20, 0);
        push_beats(3, 1, 8'h30, 1);
        for (int k = 0; k < 30; k++) step();
        check("mb_ngrants", glog.size(), 3);
        if (glog.size() == 3) begin
            check("mb_g0", glog[0], 2); check("mb_g1", glog[1], 3); check("mb_g2", glog[2], 2);
            check("mb_w0", wpg[0], 8); check("mb_w1", wpg[1], 1); check("mb_w2", wpg[2], 4);
        end
        exp_w.delete();
        for (int k = 0; k < 8; k++) exp_w.push_back(8'h20 + k);
        exp_w.push_back(8'h30);
        for (int k = 8; k < 12; k++) exp_w.push_back(8'h20 + k);
        check("mb_nwrites", wlog.size(), exp_w.size());
        for (int k = 0; k < exp_w.size(); k++)
            if (k < wlog.size()) check("mb_order", wlog[k], exp_w[k]);

        // FIFO full for five cycles in the middle of a burst.
        reset_dut();
        push_beats(1, 6, 8'h40, 0);
        for (int k = 0; k < 20; k++) begin
            tv_full = (k >= 3 && k < 8);
            step();
            if (tv_full) begin
                check("full_wr_en", 32'(fifo_wr_en), 0);
                check("full_ready", 32'(req_ready), 0);
            end
        end
        tv_full = 0;
        check("full_nwrites", wlog.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < wlog.size()) check("full_order", wlog[k], 8'h40 + k);

        // Reset after two of four beats abandons the burst; 0 wins next.
        reset_dut();
        push_beats(1, 4, 8'h50, 0);
        for (int k = 0; k < 3; k++) step();
        check("rst_pre_writes", wlog.size(), 2);
        tv_rst = 1;
        step();
        check("rst_cycle_wr", 32'(fifo_wr_en), 0);
        tv_rst = 0;
        nw = wlog.size();
        glog.delete();
        push_beats(0, 2, 8'h60, 0);
        step();
        check("rst_after_wr", 32'(fifo_wr_en), 0);
        check("rst_after_busy", 32'(busy), 0);
        for (int k = 0; k < 10; k++) step();
        check("rst_nw_frozen", nw, 2);
        if (glog.size() > 0) check("rst_first_grant", glog[0], 0);
        else check("rst_first_grant", 32'hFFFF_FFFF, 0);

        // Requesters 0 and 1 both continuously valid.
        reset_dut();
        push_beats(0, 4, 8'h70, 1);
        push_beats(1, 4, 8'h80, 1);
        for (int k = 0; k < 18; k++) step();
        check("p0_ngrants", glog.size(), 8);
        for (int k = 0; k < 4; k++) begin
`ifdef FIFO_WR_ARBITER_PRIO0_EN
            if (k < glog.size()) check("p0_order", glog[k], 0);
`else
            if (k < glog.size()) check("p0_order", glog[k], k % 2);
`endif
        end

        // Random traffic, back-pressure, valid drops and occasional reset.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 3 && $urandom_range(3) == 0)
                    srcq[i].push_back('{d: 8'($urandom), l: ($urandom_range(2) == 0)});
                drop[i] = ($urandom_range(4) == 0);
            end
            tv_full = ($urandom_range(3) == 0);
            tv_rst  = ($urandom_range(149) == 0);
            step();
        end
        tv_rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
